// File: rtl/mips_multicycle_cpu_bus.sv
// Multicycle, non-pipelined MIPS32 subset CPU on a single shared memory bus.
// Every instruction walks FETCH -> DECODE -> EXECUTE -> MEMORY_ACCESS -> WRITE_BACK.
// Branches and jumps have one architectural delay slot: the target is parked
// in a pending register and applied at the next DECODE.
// Ports:
//   clk, reset (async, active-low)
//   active       high while executing, low in reset and after halt (fetch of PC 0)
//   register_v0  live copy of GPR $2
//   address/read/write/writedata/byteenable  memory request (word accesses only)
//   readdata     valid the cycle after a read is accepted
//   waitrequest  stalls any cycle carrying read or write
//   state        FSM state (FETCH=0 .. WRITE_BACK=4)
module mips_multicycle_cpu_bus #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'b000,
    S_DECODE  = 3'b001,
    S_EXECUTE = 3'b010,
    S_MEM     = 3'b011,
    S_WB      = 3'b100
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, aluout_q, br_tgt_q, addr_q, wdata_q;
  logic        br_pend_q, active_q, read_q, write_q;
  logic [31:0] gpr_q [32];

  // Instruction fields of the latched IR
  logic [5:0]         op, funct;
  logic [4:0]         rt, rd, shamt;
  logic [15:0]        imm;
  logic signed [31:0] simm, a_s, b_s;
  logic [31:0]        zimm;

  // Combinational execute / write-back results
  logic [31:0] alu_d, jmp_tgt_d, wb_data_d;
  logic        jmp_d, wb_en_d, is_lw_d, is_sw_d;
  logic [4:0]  wb_reg_d;

  assign op    = ir_q[31:26];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign imm   = ir_q[15:0];
  assign simm  = {{16{imm[15]}}, imm};
  assign zimm  = {16'h0000, imm};
  assign a_s   = a_q;
  assign b_s   = b_q;

  always_comb begin
    alu_d     = '0;
    jmp_d     = 1'b0;
    jmp_tgt_d = '0;
    wb_en_d   = 1'b0;
    wb_reg_d  = rt;
    is_lw_d   = 1'b0;
    is_sw_d   = 1'b0;
    case (op)
      6'h00: begin
        wb_reg_d = rd;
        wb_en_d  = 1'b1;
        case (funct)
          6'h21: alu_d = a_q + b_q;
          6'h23: alu_d = a_q - b_q;
          6'h24: alu_d = a_q & b_q;
          6'h25: alu_d = a_q | b_q;
          6'h26: alu_d = a_q ^ b_q;
          6'h2A: alu_d = {31'b0, a_s < b_s};
          6'h2B: alu_d = {31'b0, a_q < b_q};
          6'h00: alu_d = b_q << shamt;
          6'h02: alu_d = b_q >> shamt;
          6'h03: alu_d = b_s >>> shamt;
          6'h08: begin
            wb_en_d   = 1'b0;
            jmp_d     = 1'b1;
            jmp_tgt_d = a_q;
          end
          default: wb_en_d = 1'b0;
        endcase
      end
      // pc_q already holds the delay-slot PC during EXECUTE
      6'h02: begin
        jmp_d     = 1'b1;
        jmp_tgt_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      end
      6'h03: begin
        jmp_d     = 1'b1;
        jmp_tgt_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        wb_en_d   = 1'b1;
        wb_reg_d  = 5'd31;
        alu_d     = pc_q + 32'd4;
      end
      6'h04: begin
        jmp_d     = (a_q == b_q);
        jmp_tgt_d = pc_q + (simm <<< 2);
      end
      6'h05: begin
        jmp_d     = (a_q != b_q);
        jmp_tgt_d = pc_q + (simm <<< 2);
      end
      6'h09: begin alu_d = a_q + simm;               wb_en_d = 1'b1; end
      6'h0A: begin alu_d = {31'b0, a_s < simm};      wb_en_d = 1'b1; end
      6'h0B: begin alu_d = {31'b0, a_q < simm};      wb_en_d = 1'b1; end
      6'h0C: begin alu_d = a_q & zimm;               wb_en_d = 1'b1; end
      6'h0D: begin alu_d = a_q | zimm;               wb_en_d = 1'b1; end
      6'h0E: begin alu_d = a_q ^ zimm;               wb_en_d = 1'b1; end
      6'h0F: begin alu_d = {imm, 16'h0000};          wb_en_d = 1'b1; end
      6'h23: begin alu_d = a_q + simm; is_lw_d = 1'b1; wb_en_d = 1'b1; end
      6'h2B: begin alu_d = a_q + simm; is_sw_d = 1'b1; end
      default: ;
    endcase
  end

  assign wb_data_d = is_lw_d ? readdata : aluout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_VECTOR;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      aluout_q  <= '0;
      br_pend_q <= 1'b0;
      br_tgt_q  <= '0;
      active_q  <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (!active_q) begin
      // Leaving reset: start fetching. Once halted PC is 0, so this never re-arms.
      if (pc_q != 32'd0) begin
        active_q <= 1'b1;
        read_q   <= 1'b1;
        addr_q   <= {pc_q[31:2], 2'b00};
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!waitrequest) begin
            read_q  <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          ir_q      <= readdata;
          a_q       <= gpr_q[readdata[25:21]];
          b_q       <= gpr_q[readdata[20:16]];
          pc_q      <= br_pend_q ? br_tgt_q : pc_q + 32'd4;
          br_pend_q <= 1'b0;
          state_q   <= S_EXECUTE;
        end
        S_EXECUTE: begin
          aluout_q <= alu_d;
          if (jmp_d) begin
            br_pend_q <= 1'b1;
            br_tgt_q  <= jmp_tgt_d;
          end
          if (is_lw_d || is_sw_d) begin
            addr_q  <= {alu_d[31:2], 2'b00};
            read_q  <= is_lw_d;
            write_q <= is_sw_d;
            wdata_q <= b_q;
          end
          state_q <= S_MEM;
        end
        S_MEM: begin
          if (!((read_q || write_q) && waitrequest)) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          if (wb_en_d && wb_reg_d != 5'd0) gpr_q[wb_reg_d] <= wb_data_d;
          state_q <= S_FETCH;
          // Outputs for the coming FETCH are registered here; PC 0 means halt.
          if (pc_q == 32'd0) begin
            active_q <= 1'b0;
          end else begin
            read_q <= 1'b1;
            addr_q <= {pc_q[31:2], 2'b00};
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign active      = active_q;
  assign register_v0 = gpr_q[2];
  assign address     = addr_q;
  assign read        = read_q;
  assign write       = write_q;
  assign writedata   = wdata_q;
  assign byteenable  = 4'b1111;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_cpu_bus.sv
module tb_mips_multicycle_cpu_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] B = 32'hBFC00000;

  mips_multicycle_cpu_bus #(.RESET_VECTOR(B)) dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest),
    .state(state)
  );

  always #5 clk = ~clk;

  // Word-addressed RAM: code at B (index 0..), data at byte 0x200 (index 128).
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!waitrequest) begin
      if (read)  readdata <= mem[address[9:2]];
      if (write) mem[address[9:2]] <= writedata;
    end
  end

  typedef struct {
    logic [31:0] pc;
    int          fstall;
    int          mstall;
    int          mkind;   // 0 none, 1 load, 2 store
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [31:0] v0;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'h24020005; // addiu $2,$0,5
    mem[1]  = 32'h2442FFFF; // addiu $2,$2,-1
    mem[2]  = 32'h3C031234; // lui   $3,0x1234
    mem[3]  = 32'h34635678; // ori   $3,$3,0x5678
    mem[4]  = 32'hAC030200; // sw    $3,0x200($0)
    mem[5]  = 32'h8C020200; // lw    $2,0x200($0)
    mem[6]  = 32'h10000002; // beq   $0,$0,+2 -> B+0x24
    mem[7]  = 32'h24420001; // addiu $2,$2,1 (delay slot)
    mem[8]  = 32'h24020077; // skipped
    mem[9]  = 32'h00431023; // subu  $2,$2,$3
    mem[10] = 32'h00000008; // jr    $0
    mem[11] = 32'h00000000; // nop (delay slot)
    readdata = 32'h0;

    vt[0]  = '{B + 32'h00, 0, 0, 0, 32'h0,   32'h0,        32'h00000005};
    vt[1]  = '{B + 32'h04, 0, 0, 0, 32'h0,   32'h0,        32'h00000004};
    vt[2]  = '{B + 32'h08, 0, 0, 0, 32'h0,   32'h0,        32'h00000004};
    vt[3]  = '{B + 32'h0C, 3, 0, 0, 32'h0,   32'h0,        32'h00000004};
    vt[4]  = '{B + 32'h10, 0, 2, 2, 32'h200, 32'h12345678, 32'h00000004};
    vt[5]  = '{B + 32'h14, 0, 0, 1, 32'h200, 32'h0,        32'h12345678};
    vt[6]  = '{B + 32'h18, 0, 0, 0, 32'h0,   32'h0,        32'h12345678};
    vt[7]  = '{B + 32'h1C, 0, 0, 0, 32'h0,   32'h0,        32'h12345679};
    vt[8]  = '{B + 32'h24, 0, 0, 0, 32'h0,   32'h0,        32'h00000001};
    vt[9]  = '{B + 32'h28, 0, 0, 0, 32'h0,   32'h0,        32'h00000001};
    vt[10] = '{B + 32'h2C, 0, 0, 0, 32'h0,   32'h0,        32'h00000001};

    reset = 1'b0;
    waitrequest = 1'b0;
    @(negedge clk);
    chk("rst_state", {29'b0, state}, 32'd0);
    chk("rst_read", {31'b0, read}, 32'd0);
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_active", {31'b0, active}, 32'd0);
    chk("rst_addr", address, 32'd0);
    chk("rst_wdata", writedata, 32'd0);
    chk("rst_v0", register_v0, 32'd0);
    reset = 1'b1;
    tick();
    chk("start_active", {31'b0, active}, 32'd1);
    chk("byteenable", {28'b0, byteenable}, 32'hF);

    for (int i = 0; i < 11; i++) begin
      chk("fetch_state", {29'b0, state}, 32'd0);
      chk("fetch_read", {31'b0, read}, 32'd1);
      chk("fetch_addr", address, vt[i].pc);
      if (vt[i].fstall > 0) begin
        waitrequest = 1'b1;
        for (int k = 0; k < vt[i].fstall; k++) begin
          tick();
          chk("fstall_state", {29'b0, state}, 32'd0);
          chk("fstall_read", {31'b0, read}, 32'd1);
          chk("fstall_addr", address, vt[i].pc);
        end
        waitrequest = 1'b0;
      end
      tick();
      chk("decode_state", {29'b0, state}, 32'd1);
      tick();
      chk("exec_state", {29'b0, state}, 32'd2);
      tick();
      chk("mem_state", {29'b0, state}, 32'd3);
      chk("mem_read", {31'b0, read}, (vt[i].mkind == 1) ? 32'd1 : 32'd0);
      chk("mem_write", {31'b0, write}, (vt[i].mkind == 2) ? 32'd1 : 32'd0);
      if (vt[i].mkind != 0) chk("mem_addr", address, vt[i].maddr);
      if (vt[i].mkind == 2) chk("mem_wdata", writedata, vt[i].wdata);
      if (vt[i].mstall > 0) begin
        waitrequest = 1'b1;
        for (int k = 0; k < vt[i].mstall; k++) begin
          tick();
          chk("mstall_state", {29'b0, state}, 32'd3);
          chk("mstall_write", {31'b0, write}, (vt[i].mkind == 2) ? 32'd1 : 32'd0);
          chk("mstall_addr", address, vt[i].maddr);
          chk("mstall_wdata", writedata, vt[i].wdata);
        end
        waitrequest = 1'b0;
      end
      tick();
      chk("wb_state", {29'b0, state}, 32'd4);
      tick();
      chk("wb_v0", register_v0, vt[i].v0);
    end

    // JR $0 with NOP delay slot: now sitting in the FETCH of address 0
    for (int k = 0; k < 4; k++) begin
      chk("halt_active", {31'b0, active}, 32'd0);
      chk("halt_read", {31'b0, read}, 32'd0);
      chk("halt_write", {31'b0, write}, 32'd0);
      chk("halt_state", {29'b0, state}, 32'd0);
      tick();
    end

    // Reset while halted clears the register file
    reset = 1'b0;
    #1;
    chk("rst2_v0", register_v0, 32'd0);
    chk("rst2_state", {29'b0, state}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rst2_fetch_addr", address, B);
    chk("rst2_fetch_read", {31'b0, read}, 32'd1);
    tick(); tick(); tick(); tick();
    chk("abort_wb_state", {29'b0, state}, 32'd4);
    // Reset in WRITE_BACK of addiu $2,$0,5 must drop the write
    reset = 1'b0;
    tick();
    chk("abort_v0", register_v0, 32'd0);
    chk("abort_state", {29'b0, state}, 32'd0);
    chk("abort_active", {31'b0, active}, 32'd0);
    chk("abort_read", {31'b0, read}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
